// File: rtl/op_dispatch_stage_if.sv
// op_dispatch_stage_if
//   Bundles every signal of the operand dispatch stage: the operand input
//   handshake, the issue/complete link to the compute stage, the result
//   output handshake, and the status outputs (busy, err_cnt, fsm_state).
//   Modports:
//     slave  - the dispatch stage itself
//     master - the environment around it (feeder, compute stage, consumer)
//   Handshake rule for both in_* and out_*: a transfer happens on a rising
//   clk edge where valid and ready are both 1. A valid, once raised, holds its
//   payload until that edge. ready may change freely.
interface op_dispatch_stage_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic        [7:0]  in_b;
  logic               start;
  logic signed [15:0] op_a;
  logic        [7:0]  op_b;
  logic               done;
  logic signed [31:0] res_1;
  logic        [15:0] res_2;
  logic        [2:0]  res_status;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_r1;
  logic        [15:0] out_r2;
  logic        [2:0]  out_status;
  logic               busy;
  logic        [7:0]  err_cnt;
  logic        [1:0]  fsm_state;

  modport slave (
    input  in_valid, in_a, in_b, done, res_1, res_2, res_status, out_ready,
    output in_ready, start, op_a, op_b, out_valid, out_r1, out_r2, out_status,
           busy, err_cnt, fsm_state
  );

  modport master (
    output in_valid, in_a, in_b, done, res_1, res_2, res_status, out_ready,
    input  in_ready, start, op_a, op_b, out_valid, out_r1, out_r2, out_status,
           busy, err_cnt, fsm_state
  );
endinterface

// File: rtl/op_dispatch_stage.sv
// op_dispatch_stage
//   Feeder for the multiply/add compute stage. Operand pairs are buffered in
//   a DEPTH-entry FIFO and issued one at a time: a 1-cycle start pulse with
//   op_a/op_b held until the op resolves. The stage waits for done, captures
//   res_1/res_2/res_status and presents them on the out_* handshake. If done
//   does not arrive within TIMEOUT wait cycles the op resolves with zero
//   results and status 3'b001, and err_cnt (saturating) is bumped.
//   Ports:
//     clk   - single clock, all logic on posedge
//     rst_n - synchronous active-low reset
//     bus   - op_dispatch_stage_if.slave (in_*, start/op_*, done/res_*,
//             out_*, busy, err_cnt, fsm_state debug view of the FSM)
module op_dispatch_stage #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  op_dispatch_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]   mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    timer;

  logic full;
  logic push;
  logic pop;
  logic timed_out;

  // in_ready depends only on the registered count, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign full      = (count == (AW + 1)'(DEPTH));
  assign push      = bus.in_valid && !full;
  assign pop       = (state == IDLE) && (count != '0);
  assign timed_out = (timer == 8'(TIMEOUT - 1));

  assign bus.in_ready  = !full;
  assign bus.start     = (state == ISSUE);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE) || (count != '0);
  assign bus.fsm_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pop) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.done || timed_out) state_nxt = HOLD;
      HOLD:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      timer          <= '0;
      bus.op_a       <= '0;
      bus.op_b       <= '0;
      bus.out_r1     <= '0;
      bus.out_r2     <= '0;
      bus.out_status <= '0;
      bus.err_cnt    <= '0;
    end else begin
      state <= state_nxt;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case (state)
        IDLE: begin
          if (pop) begin
            bus.op_a <= mem_a[rd_ptr];
            bus.op_b <= mem_b[rd_ptr];
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          // done has priority over a timeout landing in the same cycle.
          if (bus.done) begin
            bus.out_r1     <= bus.res_1;
            bus.out_r2     <= bus.res_2;
            bus.out_status <= bus.res_status;
          end else if (timed_out) begin
            bus.out_r1     <= '0;
            bus.out_r2     <= '0;
            bus.out_status <= 3'b001;
            if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_op_dispatch_stage.sv
// tb_op_dispatch_stage
//   Directed plus randomized bench for op_dispatch_stage. A compute-stage
//   responder answers each start after a per-op delay (0 = never answers),
//   a monitor checks every presented result against the expected queue, and
//   the main sequence drives operands, out_ready and reset.
module tb_op_dispatch_stage;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic signed [15:0] a;
    logic        [7:0]  b;
    int                 delay;
    logic signed [31:0] r1;
    logic        [15:0] r2;
    logic        [2:0]  st;
  } op_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  op_dispatch_stage_if bus ();

  op_dispatch_stage #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard state
  op_t         op_q[$];    // accepted ops not yet seen on start
  logic [50:0] exp_q[$];   // {r1, r2, status} expected on out_*
  int n_cmp       = 0;
  int n_fail      = 0;
  int model_err   = 0;
  int n_accepted  = 0;
  int n_starts    = 0;
  int start_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int d);
    return (d >= 1 && d <= TIMEOUT) ? 2 + d : 2 + TIMEOUT;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: offer one pair, wait (bounded) for acceptance, record the model
  task automatic push(input logic signed [15:0] a, input logic [7:0] b, input int d,
                      input logic signed [31:0] r1, input logic [15:0] r2, input logic [2:0] st);
    int  w;
    op_t o;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("push_stall", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
    end else begin
      step();
      bus.in_valid = 1'b0;
      o = '{a, b, d, r1, r2, st};
      op_q.push_back(o);
      n_accepted++;
      if (d >= 1 && d <= TIMEOUT) exp_q.push_back({r1, r2, st});
      else begin
        exp_q.push_back({32'd0, 16'd0, 3'b001});
        if (model_err < 255) model_err++;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0) && w < 3000) begin
      step();
      w++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) step();
    @(negedge clk);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err_cnt"}, bus.err_cnt, model_err);
    step();
  endtask

  // push with out_ready high, check push-to-out_valid latency, drain
  task automatic run_single(input string tag, input logic signed [15:0] a, input logic [7:0] b,
                            input int d, input logic signed [31:0] r1, input logic [15:0] r2,
                            input logic [2:0] st);
    int lat;
    bus.out_ready = 1'b1;
    push(a, b, d, r1, r2, st);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat(d));
    wait_idle(tag);
  endtask

  // compute-stage responder
  initial begin : responder
    op_t cur;
    bus.done       = 1'b0;
    bus.res_1      = '0;
    bus.res_2      = '0;
    bus.res_status = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.start) begin
        n_starts++;
        if (op_q.size() == 0) check("start_unexpected", 1, 0);
        else begin
          cur = op_q.pop_front();
          check("op_a", bus.op_a, cur.a);
          check("op_b", bus.op_b, cur.b);
          if (cur.delay > 0) begin
            repeat (cur.delay) @(posedge clk);
            #1;
            bus.done       = 1'b1;
            bus.res_1      = cur.r1;
            bus.res_2      = cur.r2;
            bus.res_status = cur.st;
            @(posedge clk);
            #1;
            bus.done       = 1'b0;
            bus.res_1      = $urandom;
            bus.res_2      = 16'($urandom);
            bus.res_status = 3'($urandom);
          end
        end
      end
    end
  end

  // output monitor: every presented result must match the queue head
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.start) start_cycles++;
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) check("out_unexpected", 1, 0);
        else begin
          check("out_r1", bus.out_r1, exp_q[0][50:19]);
          check("out_r2", bus.out_r2, exp_q[0][18:3]);
          check("out_status", bus.out_status, exp_q[0][2:0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        check("start_in_hold", bus.start, 0);
      end
    end
  end

  initial begin : main
    int s0;
    int w;
    logic signed [15:0] ra;
    logic        [7:0]  rb;
    int                 rd;
    int                 sel;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_start", bus.start, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_op_a", bus.op_a, 0);
    check("rst_op_b", bus.op_b, 0);
    check("rst_out_r1", bus.out_r1, 0);
    check("rst_out_r2", bus.out_r2, 0);
    check("rst_out_status", bus.out_status, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    step();

    // basic op, timeout, next op normal, done exactly on last wait cycle, late done
    run_single("basic", -16'sd3, 8'd5, 1, 32'sd9, 16'd10, 3'b111);
    run_single("timeout", 16'sd1234, 8'd77, 0, 32'sd1, 16'd2, 3'b010);
    run_single("after_to", 16'sd7, 8'd8, 2, -32'sd56, 16'd15, 3'b000);
    run_single("done_edge", -16'sd100, 8'd200, TIMEOUT, 32'sh1234_5678, 16'hBEEF, 3'b100);
    run_single("late_done", 16'sd42, 8'd3, TIMEOUT + 1, 32'sd5, 16'd6, 3'b011);

    // hold result with out_ready low; FIFO fills to DEPTH while held
    bus.out_ready = 1'b0;
    push(16'sd11, 8'd1, 1, 32'sd101, 16'd201, 3'b101);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      step();
      w++;
    end
    check("hold_reached", bus.out_valid, 1);
    for (int i = 0; i < DEPTH; i++)
      push(16'(20 + i), 8'(i), 1 + i, 32'(300 + i), 16'(400 + i), 3'(i));
    @(negedge clk);
    check("full_in_ready", bus.in_ready, (op_q.size() < DEPTH) ? 1 : 0);
    check("full_busy", bus.busy, 1);
    step();
    repeat (10) step();
    bus.in_valid = 1'b1;
    bus.in_a     = -16'sd9;
    bus.in_b     = 8'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fifth_held", bus.in_ready, (op_q.size() < DEPTH) ? 1 : 0);
      step();
    end
    bus.out_ready = 1'b1;
    push(-16'sd9, 8'd99, 3, -32'sd7, 16'd77, 3'b110);
    wait_idle("full");

    // reset while waiting for done; the late done must be ignored
    bus.out_ready = 1'b1;
    s0 = n_starts;
    push(16'sd50, 8'd60, 10, 32'sd1, 16'd1, 3'b111);
    w = 0;
    while (n_starts == s0 && w < 20) begin
      step();
      w++;
    end
    check("rst_mid_started", n_starts, s0 + 1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    model_err = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_start", bus.start, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_out_r1", bus.out_r1, 0);
      check("mid_rst_out_status", bus.out_status, 0);
      check("mid_rst_err_cnt", bus.err_cnt, 0);
      step();
    end

    // randomized ops with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      rd = 0;
      else if (sel == 1) rd = $urandom_range(TIMEOUT + 1, TIMEOUT + 2);
      else               rd = $urandom_range(1, TIMEOUT);
      bus.out_ready = 1'b1;
      push(ra, rb, rd, $urandom, 16'($urandom), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    bus.out_ready = 1'b1;
    wait_idle("random");

    // drive err_cnt into saturation
    for (int i = 0; i < 260; i++)
      push(16'(i), 8'(i), 0, 32'd0, 16'd0, 3'd0);
    wait_idle("saturate");
    check("err_cnt_sat", bus.err_cnt, 255);
    check("start_pulses", start_cycles, n_accepted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
